// File: rtl/beep_sched.sv
// beep_sched: fixed-priority buzzer scheduler for alarm, keypad click and
// melody requesters; generates the square wave and a silent gap per note.
module beep_sched #(
  parameter int unsigned PW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned GAP_CYC = 50000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    req,
  input  logic [PW-1:0] half_period0,
  input  logic [PW-1:0] half_period1,
  input  logic [PW-1:0] half_period2,
  input  logic [DW-1:0] duration0,
  input  logic [DW-1:0] duration1,
  input  logic [DW-1:0] duration2,
  input  logic          abort,
  output logic [2:0]    ack,
  output logic [2:0]    done,
  output logic          aborted,
  output logic          busy,
  output logic [1:0]    owner,
  output logic          beep1
);

  localparam int unsigned GW = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] hp_q, hp_d;
  logic [PW-1:0] tc_q, tc_d;
  logic [DW-1:0] dc_q, dc_d;
  logic [GW-1:0] gc_q, gc_d;
  logic [2:0]    ack_q, ack_d;
  logic [2:0]    done_q, done_d;
  logic          abrt_q, abrt_d;
  logic          busy_q, busy_d;
  logic          beep_q, beep_d;
  logic [1:0]    own_q, own_d;

  logic [1:0]    win;
  logic [PW-1:0] win_hp;
  logic [DW-1:0] win_dur;

  function automatic logic [2:0] oh(input logic [1:0] i);
    oh = 3'b001 << i;
  endfunction

  always_comb begin
    win     = 2'd0;
    win_hp  = half_period0;
    win_dur = duration0;
    if (req[0]) begin
      win     = 2'd0;
      win_hp  = half_period0;
      win_dur = duration0;
    end else if (req[1]) begin
      win     = 2'd1;
      win_hp  = half_period1;
      win_dur = duration1;
    end else begin
      win     = 2'd2;
      win_hp  = half_period2;
      win_dur = duration2;
    end
  end

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    tc_d    = tc_q;
    dc_d    = dc_q;
    gc_d    = gc_q;
    ack_d   = 3'b000;
    done_d  = 3'b000;
    abrt_d  = 1'b0;
    busy_d  = busy_q;
    beep_d  = beep_q;
    own_d   = own_q;
    case (state_q)
      IDLE: begin
        beep_d = 1'b0;
        if (|req) begin
          ack_d  = oh(win);
          own_d  = win;
          busy_d = 1'b1;
          hp_d   = win_hp;
          tc_d   = '0;
          if (win_dur != '0) begin
            state_d = PLAY;
            dc_d    = win_dur;
          end else begin
            state_d = GAP;
            done_d  = oh(win);
            gc_d    = GW'(GAP_CYC);
          end
        end
      end
      PLAY: begin
        // last-cycle completion outranks a coincident abort
        if (dc_q == DW'(1) || abort) begin
          state_d = GAP;
          beep_d  = 1'b0;
          done_d  = oh(own_q);
          abrt_d  = (dc_q != DW'(1));
          gc_d    = GW'(GAP_CYC);
          dc_d    = '0;
          tc_d    = '0;
        end else begin
          dc_d = dc_q - 1'b1;
          if (hp_q != '0) begin
            if (tc_q == hp_q - 1'b1) begin
              beep_d = ~beep_q;
              tc_d   = '0;
            end else begin
              tc_d = tc_q + 1'b1;
            end
          end
        end
      end
      GAP: begin
        beep_d = 1'b0;
        if (gc_q == GW'(1)) begin
          state_d = IDLE;
          own_d   = 2'd3;
          busy_d  = 1'b0;
          gc_d    = '0;
        end else begin
          gc_d = gc_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        own_d   = 2'd3;
        busy_d  = 1'b0;
        beep_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      hp_q    <= '0;
      tc_q    <= '0;
      dc_q    <= '0;
      gc_q    <= '0;
      ack_q   <= 3'b000;
      done_q  <= 3'b000;
      abrt_q  <= 1'b0;
      busy_q  <= 1'b0;
      beep_q  <= 1'b0;
      own_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      tc_q    <= tc_d;
      dc_q    <= dc_d;
      gc_q    <= gc_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      abrt_q  <= abrt_d;
      busy_q  <= busy_d;
      beep_q  <= beep_d;
      own_q   <= own_d;
    end
  end

  assign ack     = ack_q;
  assign done    = done_q;
  assign aborted = abrt_q;
  assign busy    = busy_q;
  assign owner   = own_q;
  assign beep1   = beep_q;

endmodule

// File: tb/tb_beep_sched.sv
// tb_beep_sched: directed checks of arbitration, tone timing,
// gap, abort and reset for beep_sched.
module tb_beep_sched;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [15:0] hp_v [3];
  logic [15:0] dur_v [3];
  logic        abort;
  logic [2:0]  ack;
  logic [2:0]  done;
  logic        aborted;
  logic        busy;
  logic [1:0]  owner;
  logic        beep1;

  int checks;
  int errors;

  beep_sched #(
    .PW(16),
    .DW(16),
    .GAP_CYC(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .half_period0(hp_v[0]),
    .half_period1(hp_v[1]),
    .half_period2(hp_v[2]),
    .duration0(dur_v[0]),
    .duration1(dur_v[1]),
    .duration2(dur_v[2]),
    .abort(abort),
    .ack(ack),
    .done(done),
    .aborted(aborted),
    .busy(busy),
    .owner(owner),
    .beep1(beep1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] oh(input int i);
    logic [2:0] one;
    one = 3'b001;
    return one << i;
  endfunction

  // Caller sets operands and req before the grant edge.
  task automatic play_note(input int i, input int hp,
                           input int dur, input int abort_at,
                           input bit exp_abort);
    logic [31:0] eb;
    step();
    chk("grant_ack", 32'(ack), 32'(oh(i)));
    chk("grant_owner", 32'(owner), i);
    chk("grant_busy", 32'(busy), 1);
    req[i]   = 1'b0;
    hp_v[i]  = 16'hffff;
    dur_v[i] = 16'hffff;
    for (int k = 1; k <= dur; k++) begin
      eb = (hp == 0) ? 0 : ((k - 1) / hp) % 2;
      chk("play_beep", 32'(beep1), eb);
      chk("play_done", 32'(done), 0);
      chk("play_owner", 32'(owner), i);
      if (k == 2) chk("ack_pulse", 32'(ack), 0);
      if (k == abort_at) abort = 1'b1;
      step();
      abort = 1'b0;
      if (k == abort_at) break;
    end
    chk("end_done", 32'(done), 32'(oh(i)));
    chk("end_aborted", 32'(aborted), 32'(exp_abort));
    chk("end_beep", 32'(beep1), 0);
    chk("end_busy", 32'(busy), 1);
    if (dur == 0) chk("zero_ack", 32'(ack), 32'(oh(i)));
    for (int g = 2; g <= 4; g++) begin
      step();
      chk("gap_busy", 32'(busy), 1);
      chk("gap_owner", 32'(owner), i);
      chk("gap_done", 32'(done), 0);
      chk("gap_beep", 32'(beep1), 0);
    end
    step();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_owner", 32'(owner), 3);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    req    = 3'b000;
    abort  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hp_v[i]  = '0;
      dur_v[i] = '0;
    end
    step();
    step();
    chk("rst_owner", 32'(owner), 3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_beep", 32'(beep1), 0);
    chk("rst_ack", 32'(ack), 0);
    rst = 1'b1;
    step();

    // melody, hp=3 dur=12
    hp_v[2]  = 16'd3;
    dur_v[2] = 16'd12;
    req      = 3'b100;
    play_note(2, 3, 12, 0, 1'b0);

    // all three at once, fixed priority order
    hp_v[0]  = 16'd1;
    dur_v[0] = 16'd5;
    hp_v[1]  = 16'd2;
    dur_v[1] = 16'd5;
    hp_v[2]  = 16'd3;
    dur_v[2] = 16'd5;
    req      = 3'b111;
    play_note(0, 1, 5, 0, 1'b0);
    play_note(1, 2, 5, 0, 1'b0);
    play_note(2, 3, 5, 0, 1'b0);

    // zero duration, abort held high outside PLAY is ignored
    hp_v[0]  = 16'd2;
    dur_v[0] = 16'd0;
    abort    = 1'b1;
    req      = 3'b001;
    play_note(0, 2, 0, 0, 1'b0);
    abort = 1'b0;

    // rest note
    hp_v[1]  = 16'd0;
    dur_v[1] = 16'd8;
    req      = 3'b010;
    play_note(1, 0, 8, 0, 1'b0);

    // abort at PLAY cycle 10
    hp_v[2]  = 16'd2;
    dur_v[2] = 16'd100;
    req      = 3'b100;
    play_note(2, 2, 100, 10, 1'b1);

    // abort on the last PLAY cycle counts as completion
    hp_v[2]  = 16'd2;
    dur_v[2] = 16'd10;
    req      = 3'b100;
    play_note(2, 2, 10, 10, 1'b0);

    // reset mid-PLAY with req held
    hp_v[2]  = 16'd2;
    dur_v[2] = 16'd20;
    req      = 3'b100;
    step();
    chk("pre_rst_ack", 32'(ack), 32'(3'b100));
    step();
    step();
    step();
    chk("pre_rst_beep", 32'(beep1), 1);
    rst = 1'b0;
    step();
    chk("mid_rst_owner", 32'(owner), 3);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_beep", 32'(beep1), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_ack", 32'(ack), 0);
    chk("mid_rst_abrt", 32'(aborted), 0);
    rst = 1'b1;
    step();
    chk("reack_ack", 32'(ack), 32'(3'b100));
    chk("reack_owner", 32'(owner), 2);
    req = 3'b000;
    for (int n = 0; n < 200 && busy; n++) step();
    chk("drain_busy", 32'(busy), 0);
    chk("drain_owner", 32'(owner), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
